// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, LATENCY wait cycles, then a held response.
// Optional console output register at STDOUT_ADDR is enabled by defining DMEM_STDOUT_EN.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] STDOUT_ADDR = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);

    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam logic [29:0] DepthW = 30'(DEPTH);
    localparam logic [3:0]  LatW   = 4'(LATENCY);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp,
        StOut
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [31:0] mem [DEPTH];

    logic            cur_write;
    logic [31:0]     cur_addr;
    logic [31:0]     cur_wdata;
    logic [IdxW-1:0] cur_idx;
    logic            cur_stdout;
    logic            cur_err;
    logic            accept;
    logic            stdout_wr;
    logic            enter_resp;
    logic            mem_we;

    // In IDLE the live request is the transaction, so a zero-latency access can use it directly.
    always_comb begin
        cur_write = write_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == StIdle) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
    end

    assign cur_idx = cur_addr[IdxW+1:2];

`ifdef DMEM_STDOUT_EN
    assign cur_stdout = (cur_addr == STDOUT_ADDR);
`else
    assign cur_stdout = 1'b0;
`endif

    assign cur_err    = !cur_stdout &&
                        ((cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= DepthW));
    assign accept     = (state_q == StIdle) && req_valid;
    assign stdout_wr  = accept && req_write && cur_stdout;
    assign enter_resp = (accept && !stdout_wr && (LatW == 4'd0)) ||
                        ((state_q == StWait) && (cnt_q == 4'd1));
    assign mem_we     = enter_resp && cur_write && !cur_err && !cur_stdout && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

`ifdef DMEM_STDOUT_EN
    logic       out_valid_q;
    logic [7:0] out_data_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
`ifdef DMEM_STDOUT_EN
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= LatW;
                        if (stdout_wr) begin
                            state_q <= StOut;
`ifdef DMEM_STDOUT_EN
                            out_valid_q <= 1'b1;
                            out_data_q  <= req_wdata[7:0];
`endif
                        end else if (enter_resp) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (enter_resp) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'd0;
                    end
                end
                StOut: begin
`ifdef DMEM_STDOUT_EN
                    if (out_ready) begin
                        state_q      <= StResp;
                        out_valid_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'd0;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase

            // RAM access and response capture happen on the edge that enters RESP.
            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= cur_err;
                resp_rdata_q <= (cur_write || cur_err || cur_stdout) ? 32'd0 : mem[cur_idx];
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

`ifdef DMEM_STDOUT_EN
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`else
    logic unused_stdout;
    assign unused_stdout = ^{out_ready, STDOUT_ADDR};
    assign out_valid     = 1'b0;
    assign out_data      = 8'd0;
`endif

endmodule
